// File: rtl/ebr_arb_pkg.sv
// Shared definitions for the EBR access arbiter: access-width encodings,
// FSM state type and the lane-width helper.
package ebr_arb_pkg;

    localparam logic [1:0] MODE_16 = 2'd0;
    localparam logic [1:0] MODE_8  = 2'd1;
    localparam logic [1:0] MODE_4  = 2'd2;
    localparam logic [1:0] MODE_2  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait
    } state_e;

    // Lane width in bits for a given access mode.
    function automatic logic [4:0] lane_width(input logic [1:0] mode);
        logic [4:0] w;
        case (mode)
            MODE_8:  w = 5'd8;
            MODE_4:  w = 5'd4;
            MODE_2:  w = 5'd2;
            default: w = 5'd16;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ebr_lane_mapper.sv
// Combinational lane mapper: turns a (mode, lane address, data) request into
// the RAM word address, write mask, lane-replicated write data and the bit
// offset of the addressed lane. Used by both the write and read paths.
module ebr_lane_mapper
    import ebr_arb_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [10:0] addr,
    input  logic [15:0] wdata,
    output logic [7:0]  word,
    output logic [15:0] mask,
    output logic [15:0] rep_data,
    output logic [3:0]  shift
);

    logic [15:0] lane_ones;

    // Split the lane address into word/lane and replicate narrow write data.
    always_comb begin
        word     = addr[7:0];
        shift    = 4'd0;
        rep_data = wdata;
        case (mode)
            MODE_8: begin
                word     = addr[8:1];
                shift    = {addr[0], 3'b000};
                rep_data = {2{wdata[7:0]}};
            end
            MODE_4: begin
                word     = addr[9:2];
                shift    = {addr[1:0], 2'b00};
                rep_data = {4{wdata[3:0]}};
            end
            MODE_2: begin
                word     = addr[10:3];
                shift    = {addr[2:0], 1'b0};
                rep_data = {8{wdata[1:0]}};
            end
            default: ;
        endcase
    end

    // Mask is 1 for protected bits, so only the selected lane is cleared.
    always_comb begin
        lane_ones = 16'((32'd1 << lane_width(mode)) - 32'd1);
        mask      = ~(lane_ones << shift);
    end

endmodule

// File: rtl/ebr_access_arbiter.sv
// Two-requester arbiter in front of a 256x16 EBR, with per-request access
// width (16/8/4/2 bits). Round-robin between requesters, one RAM access in
// flight at a time.
// Optional: define EBR_ARB_STATS_EN to add saturating per-requester grant
// counters (r0_grants / r1_grants, STATS_W bits wide).
module ebr_access_arbiter
    import ebr_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
`ifdef EBR_ARB_STATS_EN
    ,
    parameter int unsigned STATS_W    = 16
`endif
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic        r0_we,
    input  logic [1:0]  r0_mode,
    input  logic [10:0] r0_addr,
    input  logic [15:0] r0_wdata,
    output logic        r0_rvalid,
    output logic [15:0] r0_rdata,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic        r1_we,
    input  logic [1:0]  r1_mode,
    input  logic [10:0] r1_addr,
    input  logic [15:0] r1_wdata,
    output logic        r1_rvalid,
    output logic [15:0] r1_rdata,

`ifdef EBR_ARB_STATS_EN
    output logic [STATS_W-1:0] r0_grants,
    output logic [STATS_W-1:0] r1_grants,
`endif

    output logic        ram_we,
    output logic        ram_re,
    output logic [7:0]  ram_waddr,
    output logic [7:0]  ram_raddr,
    output logic [15:0] ram_wdata,
    output logic [15:0] ram_mask,
    input  logic [15:0] ram_rdata
);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_done;

    logic        last_grant_q;
    logic        req_id_q;
    logic        req_we_q;
    logic [1:0]  req_mode_q;
    logic [10:0] req_addr_q;
    logic [15:0] req_wdata_q;

    logic        r0_rvalid_q, r1_rvalid_q;
    logic [15:0] r0_rdata_q, r1_rdata_q;

    logic        accept;
    logic [7:0]  map_word;
    logic [15:0] map_mask;
    logic [15:0] map_rep;
    logic [3:0]  map_shift;
    logic [15:0] lane_bits;

    ebr_lane_mapper u_mapper (
        .mode     (req_mode_q),
        .addr     (req_addr_q),
        .wdata    (req_wdata_q),
        .word     (map_word),
        .mask     (map_mask),
        .rep_data (map_rep),
        .shift    (map_shift)
    );

    // Grant in IDLE only; on contention the requester not served last wins.
    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (state_q == StIdle) begin
            if (r0_valid && (!r1_valid || last_grant_q)) begin
                r0_ready = 1'b1;
            end else if (r1_valid) begin
                r1_ready = 1'b1;
            end
        end
    end

    assign accept = r0_ready | r1_ready;

    // Next-state logic; rd_done marks the cycle whose ram_rdata is sampled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StIssue;
            end
            StIssue: begin
                if (req_we_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRdWait;
                    cnt_d   = 2'(RD_LATENCY);
                end
            end
            StRdWait: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    rd_done = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and read-latency counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the winning request's payload at the accept edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q <= 1'b1;
            req_id_q     <= 1'b0;
            req_we_q     <= 1'b0;
            req_mode_q   <= 2'd0;
            req_addr_q   <= 11'd0;
            req_wdata_q  <= 16'd0;
        end else if (accept) begin
            last_grant_q <= r1_ready;
            req_id_q     <= r1_ready;
            req_we_q     <= r1_ready ? r1_we    : r0_we;
            req_mode_q   <= r1_ready ? r1_mode  : r0_mode;
            req_addr_q   <= r1_ready ? r1_addr  : r0_addr;
            req_wdata_q  <= r1_ready ? r1_wdata : r0_wdata;
        end
    end

    // RAM strobes and payload are only driven during ISSUE.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = 8'd0;
        ram_raddr = 8'd0;
        ram_wdata = 16'd0;
        ram_mask  = 16'hFFFF;
        if (state_q == StIssue) begin
            if (req_we_q) begin
                ram_we    = 1'b1;
                ram_waddr = map_word;
                ram_wdata = map_rep;
                ram_mask  = map_mask;
            end else begin
                ram_re    = 1'b1;
                ram_raddr = map_word;
            end
        end
    end

    // Cleared mask bits mark the addressed lane; move it down to bit 0.
    assign lane_bits = (ram_rdata & ~map_mask) >> map_shift;

    // Read return: one-cycle rvalid pulse, rdata held until the next read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= 16'd0;
            r1_rdata_q  <= 16'd0;
        end else begin
            r0_rvalid_q <= rd_done & ~req_id_q;
            r1_rvalid_q <= rd_done & req_id_q;
            if (rd_done && !req_id_q) r0_rdata_q <= lane_bits;
            if (rd_done && req_id_q)  r1_rdata_q <= lane_bits;
        end
    end

    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;

`ifdef EBR_ARB_STATS_EN
    logic [STATS_W-1:0] r0_grants_q, r1_grants_q;

    // Saturating accept counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r0_grants_q <= '0;
            r1_grants_q <= '0;
        end else begin
            if (r0_ready && r0_grants_q != '1) r0_grants_q <= r0_grants_q + STATS_W'(1);
            if (r1_ready && r1_grants_q != '1) r1_grants_q <= r1_grants_q + STATS_W'(1);
        end
    end

    assign r0_grants = r0_grants_q;
    assign r1_grants = r1_grants_q;
`endif

endmodule

// File: tb/tb_ebr_access_arbiter.sv
// Bench for ebr_access_arbiter: two instances (RD_LATENCY 1 and 2) share the
// same request stimulus, each with its own behavioural RAM. A flat bit-array
// shadow of the memory predicts read results.
module tb_ebr_access_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    always #5 clk = ~clk;

    logic        r0_valid, r0_we, r1_valid, r1_we;
    logic [1:0]  r0_mode, r1_mode;
    logic [10:0] r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;

    logic        a_r0_ready, a_r1_ready, a_r0_rvalid, a_r1_rvalid;
    logic [15:0] a_r0_rdata, a_r1_rdata;
    logic        a_ram_we, a_ram_re;
    logic [7:0]  a_ram_waddr, a_ram_raddr;
    logic [15:0] a_ram_wdata, a_ram_mask, a_ram_rdata;

    logic        b_r0_ready, b_r1_ready, b_r0_rvalid, b_r1_rvalid;
    logic [15:0] b_r0_rdata, b_r1_rdata;
    logic        b_ram_we, b_ram_re;
    logic [7:0]  b_ram_waddr, b_ram_raddr;
    logic [15:0] b_ram_wdata, b_ram_mask, b_ram_rdata, b_stage;

`ifdef EBR_ARB_STATS_EN
    logic [15:0] a_r0_grants, a_r1_grants, b_r0_grants, b_r1_grants;
`endif

    ebr_access_arbiter #(.RD_LATENCY(1)) dut_a (
        .clk(clk), .resetn(resetn),
        .r0_valid(r0_valid), .r0_ready(a_r0_ready), .r0_we(r0_we), .r0_mode(r0_mode),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(a_r0_rvalid), .r0_rdata(a_r0_rdata),
        .r1_valid(r1_valid), .r1_ready(a_r1_ready), .r1_we(r1_we), .r1_mode(r1_mode),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(a_r1_rvalid), .r1_rdata(a_r1_rdata),
`ifdef EBR_ARB_STATS_EN
        .r0_grants(a_r0_grants), .r1_grants(a_r1_grants),
`endif
        .ram_we(a_ram_we), .ram_re(a_ram_re), .ram_waddr(a_ram_waddr), .ram_raddr(a_ram_raddr),
        .ram_wdata(a_ram_wdata), .ram_mask(a_ram_mask), .ram_rdata(a_ram_rdata)
    );

    ebr_access_arbiter #(.RD_LATENCY(2)) dut_b (
        .clk(clk), .resetn(resetn),
        .r0_valid(r0_valid), .r0_ready(b_r0_ready), .r0_we(r0_we), .r0_mode(r0_mode),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
        .r1_valid(r1_valid), .r1_ready(b_r1_ready), .r1_we(r1_we), .r1_mode(r1_mode),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
`ifdef EBR_ARB_STATS_EN
        .r0_grants(b_r0_grants), .r1_grants(b_r1_grants),
`endif
        .ram_we(b_ram_we), .ram_re(b_ram_re), .ram_waddr(b_ram_waddr), .ram_raddr(b_ram_raddr),
        .ram_wdata(b_ram_wdata), .ram_mask(b_ram_mask), .ram_rdata(b_ram_rdata)
    );

    // Behavioural RAMs: mask bit 1 = protected; read data holds until next read.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    always @(posedge clk) begin
        if (a_ram_we) mem_a[a_ram_waddr] <= (mem_a[a_ram_waddr] & a_ram_mask) | (a_ram_wdata & ~a_ram_mask);
        if (a_ram_re) a_ram_rdata <= mem_a[a_ram_raddr];
        if (b_ram_we) mem_b[b_ram_waddr] <= (mem_b[b_ram_waddr] & b_ram_mask) | (b_ram_wdata & ~b_ram_mask);
        if (b_ram_re) b_stage <= mem_b[b_ram_raddr];
        b_ram_rdata <= b_stage;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memory: lane of width w at lane address a sits at bit a*w.
    logic [4095:0] shadow = '0;

    task automatic shadow_write(input logic [1:0] mode, input logic [10:0] addr, input logic [15:0] wd);
        int w   = 16 >> mode;
        int off = (int'(addr) % (4096 / w)) * w;
        for (int i = 0; i < w; i++) shadow[off + i] = wd[i];
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] mode, input logic [10:0] addr);
        int w   = 16 >> mode;
        int off = (int'(addr) % (4096 / w)) * w;
        logic [15:0] v = '0;
        for (int i = 0; i < w; i++) v[i] = shadow[off + i];
        return v;
    endfunction

    task automatic set_req(input int who, input logic we, input logic [1:0] mode,
                           input logic [10:0] addr, input logic [15:0] wd);
        if (who == 0) begin
            r0_valid = 1'b1; r0_we = we; r0_mode = mode; r0_addr = addr; r0_wdata = wd;
        end else begin
            r1_valid = 1'b1; r1_we = we; r1_mode = mode; r1_addr = addr; r1_wdata = wd;
        end
    endtask

    // Call just after a negedge; returns #1 after the accept edge (ISSUE cycle).
    task automatic wait_accept(input int who, output bit ok, output bit other_rdy);
        ok = 1'b0;
        other_rdy = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if ((who == 0) ? a_r0_ready : a_r1_ready) begin
                other_rdy = (who == 0) ? a_r1_ready : a_r0_ready;
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (who == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
    endtask

    // Watch both instances for the read return; latency counted from accept cycle.
    task automatic collect_read(input int who, output int lat_a, output logic [15:0] d_a,
                                output int lat_b, output logic [15:0] d_b, output bit stray);
        lat_a = 0; lat_b = 0; d_a = '0; d_b = '0; stray = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (lat_a == 0 && ((who == 0) ? a_r0_rvalid : a_r1_rvalid)) begin
                lat_a = c; d_a = (who == 0) ? a_r0_rdata : a_r1_rdata;
            end
            if (lat_b == 0 && ((who == 0) ? b_r0_rvalid : b_r1_rvalid)) begin
                lat_b = c; d_b = (who == 0) ? b_r0_rdata : b_r1_rdata;
            end
            if ((who == 0) ? (a_r1_rvalid | b_r1_rvalid) : (a_r0_rvalid | b_r0_rvalid)) stray = 1'b1;
        end
    endtask

    localparam logic [85:0] IDLE_OUTS = {4'b0, 32'h0, 2'b0, 8'h0, 8'h0, 16'h0, 16'hFFFF};

    task automatic test_reset();
        logic [85:0] oa, ob;
        resetn = 1'b0;
        #1;
        oa = {a_r0_ready, a_r1_ready, a_r0_rvalid, a_r1_rvalid, a_r0_rdata, a_r1_rdata,
              a_ram_we, a_ram_re, a_ram_waddr, a_ram_raddr, a_ram_wdata, a_ram_mask};
        ob = {b_r0_ready, b_r1_ready, b_r0_rvalid, b_r1_rvalid, b_r0_rdata, b_r1_rdata,
              b_ram_we, b_ram_re, b_ram_waddr, b_ram_raddr, b_ram_wdata, b_ram_mask};
        n_checks++;
        if (oa !== IDLE_OUTS) $display("FAIL reset_outs_a got %h want %h", oa, IDLE_OUTS);
        else n_pass++;
        n_checks++;
        if (ob !== IDLE_OUTS) $display("FAIL reset_outs_b got %h want %h", ob, IDLE_OUTS);
        else n_pass++;
`ifdef EBR_ARB_STATS_EN
        n_checks++;
        if ({a_r0_grants, a_r1_grants} !== 32'h0)
            $display("FAIL reset_grants got %h want 0", {a_r0_grants, a_r1_grants});
        else n_pass++;
`endif
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_write_lanes();
        int          who_t [3] = '{0, 1, 0};
        logic [1:0]  mode_t[3] = '{2'd1, 2'd3, 2'd0};
        logic [10:0] addr_t[3] = '{11'h005, 11'h00E, 11'h7FF};
        logic [15:0] wd_t  [3] = '{16'h00A5, 16'h0002, 16'hBEEF};
        logic [41:0] exp_t [3] = '{{2'b10, 8'h02, 16'hA5A5, 16'h00FF},
                                   {2'b10, 8'h01, 16'hAAAA, 16'hCFFF},
                                   {2'b10, 8'hFF, 16'hBEEF, 16'h0000}};
        bit ok, oth;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_req(who_t[i], 1'b1, mode_t[i], addr_t[i], wd_t[i]);
            wait_accept(who_t[i], ok, oth);
            n_checks++;
            if (!ok || oth) $display("FAIL wr_accept[%0d] got ok=%0d other=%0d want ok=1 other=0", i, ok, oth);
            else n_pass++;
            if (ok) shadow_write(mode_t[i], addr_t[i], wd_t[i]);
            @(negedge clk);
            n_checks++;
            if ({a_ram_we, a_ram_re, a_ram_waddr, a_ram_wdata, a_ram_mask} !== exp_t[i])
                $display("FAIL wr_issue_a[%0d] got %h want %h", i,
                         {a_ram_we, a_ram_re, a_ram_waddr, a_ram_wdata, a_ram_mask}, exp_t[i]);
            else n_pass++;
            n_checks++;
            if ({b_ram_we, b_ram_re, b_ram_waddr, b_ram_wdata, b_ram_mask} !== exp_t[i])
                $display("FAIL wr_issue_b[%0d] got %h want %h", i,
                         {b_ram_we, b_ram_re, b_ram_waddr, b_ram_wdata, b_ram_mask}, exp_t[i]);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({a_ram_we, a_ram_re, a_ram_mask} !== {2'b00, 16'hFFFF})
                $display("FAIL wr_after[%0d] got %h want %h", i, {a_ram_we, a_ram_re, a_ram_mask},
                         {2'b00, 16'hFFFF});
            else n_pass++;
        end
    endtask

    task automatic test_read_lane();
        bit ok, oth, stray;
        int la, lb;
        logic [15:0] da, db;
        @(negedge clk);
        set_req(0, 1'b1, 2'd0, 11'h001, 16'h1234);
        wait_accept(0, ok, oth);
        if (ok) shadow_write(2'd0, 11'h001, 16'h1234);
        @(negedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 2'd2, 11'h007, 16'h0000);
        wait_accept(0, ok, oth);
        n_checks++;
        if (!ok) $display("FAIL rd_accept got ok=0 want ok=1");
        else n_pass++;
        collect_read(0, la, da, lb, db, stray);
        n_checks++;
        if (la !== 3 || da !== 16'h0001)
            $display("FAIL rd_lane_a got lat=%0d data=%h want lat=3 data=0001", la, da);
        else n_pass++;
        n_checks++;
        if (lb !== 4 || db !== 16'h0001)
            $display("FAIL rd_lane_b got lat=%0d data=%h want lat=4 data=0001", lb, db);
        else n_pass++;
        n_checks++;
        if (stray !== 1'b0) $display("FAIL rd_other_rvalid got %0d want 0", stray);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int ord_a[8], ord_b[8];
        int na = 0, nb = 0, last = 1, expw;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 2'd0, 11'h010, 16'h1111);
        set_req(1, 1'b1, 2'd0, 11'h011, 16'h2222);
        for (int cyc = 0; cyc < 40 && na < 8; cyc++) begin
            #1;
            if (a_r0_ready && a_r1_ready) begin ord_a[na] = 2; na++; end
            else if (a_r0_ready) begin ord_a[na] = 0; na++; shadow_write(2'd0, 11'h010, 16'h1111); end
            else if (a_r1_ready) begin ord_a[na] = 1; na++; shadow_write(2'd0, 11'h011, 16'h2222); end
            if (nb < 8) begin
                if (b_r0_ready && b_r1_ready) begin ord_b[nb] = 2; nb++; end
                else if (b_r0_ready) begin ord_b[nb] = 0; nb++; end
                else if (b_r1_ready) begin ord_b[nb] = 1; nb++; end
            end
            @(posedge clk);
            #1;
            if (na == 8) begin r0_valid = 1'b0; r1_valid = 1'b0; end
            @(negedge clk);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        n_checks++;
        if (na !== 8 || nb !== 8) $display("FAIL arb_count got a=%0d b=%0d want 8", na, nb);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            expw = 1 - last;
            last = expw;
            n_checks++;
            if (i < na && i < nb && (ord_a[i] !== expw || ord_b[i] !== expw))
                $display("FAIL arb_order[%0d] got a=%0d b=%0d want %0d", i, ord_a[i], ord_b[i], expw);
            else n_pass++;
        end
`ifdef EBR_ARB_STATS_EN
        n_checks++;
        if ({a_r0_grants, a_r1_grants} !== {16'd4, 16'd4})
            $display("FAIL arb_grants got r0=%0d r1=%0d want 4 4", a_r0_grants, a_r1_grants);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_rdwait();
        bit ok, oth, seen;
        logic [85:0] oa, ob;
        @(negedge clk);
        set_req(1, 1'b0, 2'd0, 11'h010, 16'h0000);
        wait_accept(1, ok, oth);
        @(negedge clk);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        oa = {a_r0_ready, a_r1_ready, a_r0_rvalid, a_r1_rvalid, a_r0_rdata, a_r1_rdata,
              a_ram_we, a_ram_re, a_ram_waddr, a_ram_raddr, a_ram_wdata, a_ram_mask};
        ob = {b_r0_ready, b_r1_ready, b_r0_rvalid, b_r1_rvalid, b_r0_rdata, b_r1_rdata,
              b_ram_we, b_ram_re, b_ram_waddr, b_ram_raddr, b_ram_wdata, b_ram_mask};
        n_checks++;
        if (ob !== IDLE_OUTS || oa !== IDLE_OUTS)
            $display("FAIL rdwait_reset_outs got a=%h b=%h want %h", oa, ob, IDLE_OUTS);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_r0_rvalid | a_r1_rvalid | b_r0_rvalid | b_r1_rvalid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL rdwait_dropped_rvalid got %0d want 0", seen);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok, oth, stray;
        int who, w, la, lb;
        logic we;
        logic [1:0] mode;
        logic [10:0] addr;
        logic [15:0] wd, da, db, expd;
        for (int t = 0; t < 40; t++) begin
            who  = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            w    = 16 >> mode;
            addr = 11'($urandom_range(0, 4 * (16 / w) - 1));
            wd   = 16'($urandom);
            @(negedge clk);
            set_req(who, we, mode, addr, wd);
            wait_accept(who, ok, oth);
            if (we) begin
                if (ok) shadow_write(mode, addr, wd);
                @(negedge clk);
                n_checks++;
                if (!ok || a_ram_we !== 1'b1 || b_ram_we !== 1'b1)
                    $display("FAIL rand_wr[%0d] got ok=%0d we_a=%0d we_b=%0d want 1 1 1", t, ok,
                             a_ram_we, b_ram_we);
                else n_pass++;
            end else begin
                expd = model_read(mode, addr);
                collect_read(who, la, da, lb, db, stray);
                n_checks++;
                if (!ok || la !== 3 || lb !== 4 || da !== expd || db !== expd || stray)
                    $display("FAIL rand_rd[%0d] r%0d m%0d a=%h got lat=%0d/%0d data=%h/%h stray=%0d want lat=3/4 data=%h",
                             t, who, mode, addr, la, lb, da, db, stray, expd);
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        a_ram_rdata = '0; b_ram_rdata = '0; b_stage = '0;
        r0_valid = 0; r0_we = 0; r0_mode = '0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 0; r1_we = 0; r1_mode = '0; r1_addr = '0; r1_wdata = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_lanes();
        test_read_lane();
        test_arbitration();
        test_reset_rdwait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ebr_access_arbiter.md
Name: ebr_access_arbiter

Overview:
Shares one 256x16 EBR block (iCE40UP SB_RAM40_4K used in 16-bit mode) between two requesters. Each request may use a 16, 8, 4 or 2-bit access width.
- Writes: narrow data is replicated across lanes and a bit mask is generated, so only the addressed lane changes.
- Reads: the addressed lane is extracted and zero-extended.
- Sits between the camera/SPI data movers and the RAM primitive, replacing fixed-mode RAM instantiations.

Parameters:
- RD_LATENCY, 1, RAM read latency in cycles from ram_re to valid ram_rdata (legal values 1 or 2).
- STATS_W, 16, width of the grant counters (used only with EBR_ARB_STATS_EN).

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- r0_valid / r1_valid  in  1  request valid.
- r0_ready / r1_ready  out  1  request accepted this cycle (valid & ready).
- r0_we / r1_we  in  1  1 = write, 0 = read.
- r0_mode / r1_mode  in  2  access width: 0 = 16b, 1 = 8b, 2 = 4b, 3 = 2b.
- r0_addr / r1_addr  in  11  lane address, interpreted per mode.
- r0_wdata / r1_wdata  in  16  write data, LSB-aligned.
- r0_rvalid / r1_rvalid  out  1  one-cycle pulse, read data valid.
- r0_rdata / r1_rdata  out  16  read data, zero-extended lane.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_waddr / ram_raddr  out  8  RAM word address.
- ram_wdata  out  16  replicated write data.
- ram_mask  out  16  1 = bit protected (not written), matching the primitive MASK.
- ram_rdata  in  16  RAM read data.

Behaviour:
- Reset: every output is 0 and ram_mask is 0xFFFF; state IDLE; last_grant = 1.
- Reset asserted mid-operation aborts the access. No rvalid is issued for a dropped read.
- Address map (word = RAM address, lane = slot within the word; lane k occupies bits [k*w+w-1 : k*w]):
  - mode 0: word = addr[7:0], one lane, w = 16.
  - mode 1: word = addr[8:1], lane = addr[0], w = 8.
  - mode 2: word = addr[9:2], lane = addr[1:0], w = 4.
  - mode 3: word = addr[10:3], lane = addr[2:0], w = 2.
  - Unused upper address bits are ignored.
- Write data: ram_wdata = wdata[w-1:0] replicated 16/w times. ram_mask = all ones except the selected lane, which is 0. Mode 0 gives mask 0x0000.
- Read data: rdata = ram_rdata lane bits shifted to bit 0, upper bits 0.
- FSM:
  - IDLE: at most one ready is asserted, combinationally, toward the winning requester.
    - Only one valid: that requester wins.
    - Both valid: the requester != last_grant wins.
    - On accept: latch we/mode/addr/wdata and the requester id, update last_grant, go to ISSUE.
  - ISSUE: drive ram_we (write) or ram_re (read) for exactly one cycle, with address/data/mask from the latched request.
    - Write: go to IDLE.
    - Read: go to RDWAIT with counter = RD_LATENCY.
  - RDWAIT: decrement the counter. When it reaches 0, sample ram_rdata, pulse rvalid plus rdata to the latched requester, go to IDLE.
- Latency, from the accept edge:
  - Write: RAM strobe in the next cycle.
  - Read: rvalid 2 + RD_LATENCY cycles after accept.
  - Throughput: 1 write per 2 cycles; 1 read per 2 + RD_LATENCY cycles.
- Outputs outside ISSUE: ram_we = ram_re = 0 and ram_mask = 0xFFFF. rdata holds its last value; rvalid is 0.
- valid is held by the requester until ready. The request payload must be stable while valid. A valid that drops before ready is legal and ignored.
- Strict alternation under continuous contention; no starvation.

Optional Feature:
- EBR_ARB_STATS_EN defined:
  - Adds outputs r0_grants and r1_grants, each STATS_W wide.
  - Each counter increments on its requester's accept and saturates at all-ones.
  - Both counters are cleared by reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ebr_arb_pkg holds:
  - mode encodings MODE_16/MODE_8/MODE_4/MODE_2;
  - the FSM state enumeration;
  - the function returning lane width per mode.
- Sub-module ebr_lane_mapper (combinational): mode, addr and wdata in; word, mask, replicated data and lane shift out. It is shared by the write and read paths.

Test Plan:
- Reset during RDWAIT (RD_LATENCY=2): assert resetn=0 -> all outputs 0, ram_mask 0xFFFF, no rvalid after release.
- r0 write mode1 addr 0x005 wdata 0x00A5 -> next cycle ram_we=1, ram_waddr 0x02, ram_wdata 0xA5A5, ram_mask 0x00FF.
- r1 write mode3 addr 0x00E wdata 0x0002 -> ram_waddr 0x01, ram_wdata 0xAAAA, ram_mask 0xCFFF.
- RAM word 0x01 holds 0x1234; r0 read mode2 addr 0x007, RD_LATENCY=1 -> r0_rvalid 3 cycles after accept, r0_rdata 0x0001; r1_rvalid stays 0.
- Both requesters hold valid for 8 accepts after reset -> grants r0,r1,r0,r1,... (r0 first). With EBR_ARB_STATS_EN, both counters read 4.
- mode0 write addr 0x7FF wdata 0xBEEF -> ram_waddr 0xFF, ram_mask 0x0000, ram_wdata 0xBEEF (upper address bits ignored).
